// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 instruction sequence/decode controller.
package lc3_pkg;

   typedef enum logic [4:0] {
      HALTED,
      S_18,
      S_33,
      S_35,
      S_32,
      S_01,
      S_05,
      S_09,
      S_00,
      S_22,
      S_12,
      S_04,
      S_21,
      S_06,
      S_25,
      S_27,
      S_07,
      S_23,
      S_16,
      PAUSE_IR1,
      PAUSE_IR2
   } state_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] PCMUX_PC1  = 2'b00;
   localparam logic [1:0] PCMUX_BUS  = 2'b01;
   localparam logic [1:0] PCMUX_ADDR = 2'b10;

   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   // States that hold for the SRAM access time and need the wait counter.
   function automatic logic is_mem_state(state_t s);
      return (s == S_33) || (s == S_25) || (s == S_16);
   endfunction

endpackage

// File: rtl/lc3_mem_wait_ctr.sv
// Loadable 3-bit down-counter timing SRAM read/write states; done at terminal count 0.
module lc3_mem_wait_ctr
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic done
);

   localparam logic [2:0] RELOAD = 3'(MEM_WAIT);

   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = RELOAD;
      end else if (cnt_q != 3'd0) begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == 3'd0);

endmodule

// File: rtl/lc3_isdu_ctrl.sv
// LC-3 instruction sequence/decode unit: Moore FSM driving datapath loads, gates and selects.
// Optional pause states are built when LC3_PAUSE_EN is defined.
module lc3_isdu_ctrl
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_PC,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       DRMUX,
   output logic       ADDR1MUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       MIO_EN,
   output logic       Mem_OE_n,
   output logic       Mem_WE_n
);

   state_t state_q, state_d;
   logic   ctr_load, ctr_done;

   lc3_mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
      .clk   (Clk),
      .rst_n (Reset),
      .load  (ctr_load),
      .done  (ctr_done)
   );

   // Reload only on entry so the hold time is MEM_WAIT+1 cycles.
   assign ctr_load = is_mem_state(state_d) && (state_d != state_q);

`ifdef LC3_PAUSE_EN
   logic pause_exit_q, pause_exit_d;

   // Remembers whether the pause came from opcode 1101 (exit to S_18) or from fetch.
   always_comb begin
      pause_exit_d = pause_exit_q;
      if ((state_d == PAUSE_IR1) && (state_q != PAUSE_IR1)) begin
         pause_exit_d = (state_q == S_32);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pause_exit_q <= 1'b0;
      end else begin
         pause_exit_q <= pause_exit_d;
      end
   end
`else
   logic unused_continue;
   assign unused_continue = Continue;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         HALTED:    if (Run) state_d = S_18;
         S_18:      state_d = S_33;
         S_33:      if (ctr_done) state_d = S_35;
`ifdef LC3_PAUSE_EN
         S_35:      state_d = PAUSE_IR1;
`else
         S_35:      state_d = S_32;
`endif
         S_32: begin
            case (Opcode)
               OP_ADD:   state_d = S_01;
               OP_AND:   state_d = S_05;
               OP_NOT:   state_d = S_09;
               OP_BR:    state_d = S_00;
               OP_JMP:   state_d = S_12;
               OP_JSR:   state_d = S_04;
               OP_LDR:   state_d = S_06;
               OP_STR:   state_d = S_07;
`ifdef LC3_PAUSE_EN
               OP_PAUSE: state_d = PAUSE_IR1;
`else
               OP_PAUSE: state_d = S_18;
`endif
               default:  state_d = S_18;
            endcase
         end
         S_00:      state_d = BEN ? S_22 : S_18;
         S_04:      state_d = S_21;
         S_06:      state_d = S_25;
         S_25:      if (ctr_done) state_d = S_27;
         S_07:      state_d = S_23;
         S_23:      state_d = S_16;
         S_16:      if (ctr_done) state_d = S_18;
`ifdef LC3_PAUSE_EN
         PAUSE_IR1: if (Continue) state_d = PAUSE_IR2;
         PAUSE_IR2: if (!Continue) state_d = pause_exit_q ? S_18 : S_32;
`else
         PAUSE_IR1: state_d = S_18;
         PAUSE_IR2: state_d = S_18;
`endif
         S_01, S_05, S_09, S_22, S_12, S_21, S_27: state_d = S_18;
         default:   state_d = HALTED;
      endcase
   end

   always_comb begin
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_PC      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      DRMUX      = 1'b0;
      ADDR1MUX   = 1'b0;
      PCMUX      = PCMUX_PC1;
      ADDR2MUX   = ADDR2_ZERO;
      ALUK       = ALUK_ADD;
      MIO_EN     = 1'b0;
      Mem_OE_n   = 1'b1;
      Mem_WE_n   = 1'b1;
      case (state_q)
         S_18: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            LD_PC  = 1'b1;
         end
         S_33, S_25: begin
            Mem_OE_n = 1'b0;
            MIO_EN   = 1'b1;
            LD_MDR   = ctr_done;
         end
         S_35: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
         end
         S_32: LD_BEN = 1'b1;
         S_01, S_05, S_09: begin
            SR1MUX  = 1'b1;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            if (state_q == S_01) begin
               SR2MUX = IR_5;
            end else if (state_q == S_05) begin
               SR2MUX = IR_5;
               ALUK   = ALUK_AND;
            end else begin
               ALUK   = ALUK_NOT;
            end
         end
         S_22: begin
            ADDR2MUX = ADDR2_OFF9;
            PCMUX    = PCMUX_ADDR;
            LD_PC    = 1'b1;
         end
         S_12: begin
            SR1MUX  = 1'b1;
            ALUK    = ALUK_PASSA;
            GateALU = 1'b1;
            PCMUX   = PCMUX_BUS;
            LD_PC   = 1'b1;
         end
         S_04: begin
            GatePC = 1'b1;
            DRMUX  = 1'b1;
            LD_REG = 1'b1;
         end
         S_21: begin
            LD_PC = 1'b1;
            if (IR_11) begin
               ADDR2MUX = ADDR2_OFF11;
               PCMUX    = PCMUX_ADDR;
            end else begin
               SR1MUX  = 1'b1;
               ALUK    = ALUK_PASSA;
               GateALU = 1'b1;
               PCMUX   = PCMUX_BUS;
            end
         end
         S_06, S_07: begin
            SR1MUX     = 1'b1;
            ADDR1MUX   = 1'b1;
            ADDR2MUX   = ADDR2_OFF6;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
         end
         S_27: begin
            GateMDR = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         S_23: begin
            ALUK    = ALUK_PASSA;
            GateALU = 1'b1;
            LD_MDR  = 1'b1;
         end
         S_16: Mem_WE_n = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= HALTED;
      end else begin
         state_q <= state_d;
      end
   end

endmodule
